// File: rtl/matrix_b_load_ctrl_pkg.sv
// Shared definitions for the Matrix_B load controller: defaults, FSM encodings and
// the round-robin index helper.
package matrix_b_load_ctrl_pkg;

    localparam int unsigned NreqDefault  = 2;
    localparam int unsigned ColDefault   = 4;
    localparam int unsigned WidthDefault = 32;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StLoad = 2'd1;
    localparam state_t StDone = 2'd2;

    // Wrap an index that may have run past the top of the requester range by at most n.
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/matrix_b_load_ctrl_if.sv
// Requester-side and Matrix_B-side signals of the load controller, bundled as one port.
interface matrix_b_load_ctrl_if
    import matrix_b_load_ctrl_pkg::*;
#(
    parameter int unsigned NREQ  = NreqDefault,
    parameter int unsigned WIDTH = WidthDefault
);

    localparam int unsigned OwnerW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       gnt;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       wvalid;
    logic [NREQ-1:0]       wready;
    logic                  B_opcode;
    logic [WIDTH-1:0]      Data_to_B;
    logic [OwnerW-1:0]     owner;
    logic                  done;
    logic                  matrix_valid;

    modport master (
        input  req,
        input  wdata,
        input  wvalid,
        output gnt,
        output wready,
        output B_opcode,
        output Data_to_B,
        output owner,
        output done,
        output matrix_valid
    );

    modport slave (
        output req,
        output wdata,
        output wvalid,
        input  gnt,
        input  wready,
        input  B_opcode,
        input  Data_to_B,
        input  owner,
        input  done,
        input  matrix_valid
    );

endinterface

// File: rtl/matrix_b_load_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last winner and wraps.
module matrix_b_load_ctrl_rr_arbiter
    import matrix_b_load_ctrl_pkg::*;
#(
    parameter int unsigned NREQ   = NreqDefault,
    parameter int unsigned OwnerW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]   req,
    input  logic [OwnerW-1:0] last,
    output logic [NREQ-1:0]   gnt,
    output logic [OwnerW-1:0] winner
);

    logic              found;
    logic [OwnerW-1:0] idx;

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        // i runs 1..NREQ so the previous winner is checked last.
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = OwnerW'(rr_wrap(32'(last) + i, NREQ));
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                winner   = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_b_load_ctrl.sv
// Arbitrates Matrix_B write ownership among requesters and streams COL words from the
// winner into Matrix_B, flagging when a complete load is resident.
module matrix_b_load_ctrl
    import matrix_b_load_ctrl_pkg::*;
#(
    parameter int unsigned NREQ  = NreqDefault,
    parameter int unsigned COL   = ColDefault,
    parameter int unsigned WIDTH = WidthDefault
) (
    input  logic          clk,
    input  logic          reset,
    matrix_b_load_ctrl_if.master bus
);

    localparam int unsigned OwnerW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW   = (COL > 1) ? $clog2(COL) : 1;

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [OwnerW-1:0] owner_q, owner_d;
    logic [OwnerW-1:0] last_q, last_d;
    logic              b_opcode_q, b_opcode_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [OwnerW-1:0] arb_winner;
    logic [NREQ-1:0]   wready;
    logic              accept;
    logic [WIDTH-1:0]  owner_word;

    matrix_b_load_ctrl_rr_arbiter #(
        .NREQ   (NREQ),
        .OwnerW (OwnerW)
    ) u_rr_arbiter (
        .req    (bus.req),
        .last   (last_q),
        .gnt    (arb_gnt),
        .winner (arb_winner)
    );

    // Only the registered owner may hand over words, and only while loading.
    assign wready = (state_q == StLoad) ? gnt_q : '0;
    assign accept = |(bus.wvalid & wready);

    always_comb begin
        owner_word = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                owner_word = bus.wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        b_opcode_d = 1'b0;
        data_d     = data_q;
        done_d     = 1'b0;
        valid_d    = valid_q;

        case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    gnt_d   = arb_gnt;
                    owner_d = arb_winner;
                    valid_d = 1'b0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    b_opcode_d = 1'b1;
                    data_d     = owner_word;
                    if (cnt_q == CntW'(COL - 1)) begin
                        // done/matrix_valid line up with the final write strobe.
                        cnt_d   = '0;
                        gnt_d   = '0;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StDone: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            gnt_q      <= '0;
            owner_q    <= '0;
            last_q     <= OwnerW'(NREQ - 1);
            b_opcode_q <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            b_opcode_q <= b_opcode_d;
            data_q     <= data_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.wready       = wready;
    assign bus.B_opcode     = b_opcode_q;
    assign bus.Data_to_B    = data_q;
    assign bus.owner        = owner_q;
    assign bus.done         = done_q;
    assign bus.matrix_valid = valid_q;

endmodule

// File: tb/tb_matrix_b_load_ctrl.sv
// Self-checking bench for matrix_b_load_ctrl with a Matrix_B write model and a
// scoreboard of expected write words.
module tb_matrix_b_load_ctrl;

    localparam int NREQ  = 2;
    localparam int COL   = 4;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;

    matrix_b_load_ctrl_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    matrix_b_load_ctrl #(
        .NREQ  (NREQ),
        .COL   (COL),
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Matrix_B model: write_index advances only on B_opcode, shares the reset.
    logic [WIDTH-1:0] mem [COL];
    logic [1:0]       widx;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            widx <= '0;
        end else if (bus.B_opcode) begin
            mem[widx] <= bus.Data_to_B;
            widx      <= widx + 2'd1;
        end
    end

    logic [WIDTH-1:0] exp_q[$];
    bit               bop_log[$];
    int               done_cnt;
    bit               saw_dead;
    bit               saw_wr1;
    logic [WIDTH-1:0] exp_word;
    logic [WIDTH-1:0] words [COL];

    always @(negedge clk) begin
        if (!reset) begin
            bop_log.push_back(bus.B_opcode);
            if (bus.wready[1]) saw_wr1 = 1'b1;
            if (bus.done) done_cnt++;
            if (bus.B_opcode) begin
                if (bus.Data_to_B == 32'hDEAD) saw_dead = 1'b1;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL write_word: got unexpected write %0h, required none", bus.Data_to_B);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (bus.Data_to_B !== exp_word)
                        $display("FAIL write_word: got %0h required %0h", bus.Data_to_B, exp_word);
                    else
                        n_pass++;
                end
            end
            if (bus.done) begin
                n_total++;
                if (bus.B_opcode !== 1'b1)
                    $display("FAIL done_with_last_write: B_opcode %b required 1", bus.B_opcode);
                else
                    n_pass++;
            end
            if (|bus.wready) begin
                n_total++;
                if (((bus.wready & ~bus.gnt) !== 2'b00) || !$onehot(bus.wready))
                    $display("FAIL wready_owner_only: wready %b gnt %b required wready==gnt onehot",
                             bus.wready, bus.gnt);
                else
                    n_pass++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int log_ones();
        int n = 0;
        foreach (bop_log[i]) if (bop_log[i]) n++;
        return n;
    endfunction

    // Zero cycles between the first and last write strobe in the log.
    function automatic int log_gap();
        int first = -1;
        int last  = -1;
        int gaps  = 0;
        foreach (bop_log[i]) begin
            if (bop_log[i]) begin
                if (first < 0) first = i;
                last = i;
            end
        end
        if (first < 0) return -1;
        for (int i = first; i <= last; i++) if (!bop_log[i]) gaps++;
        return gaps;
    endfunction

    task automatic wait_gnt(output bit ok);
        int guard = 0;
        while (bus.gnt == '0 && guard < 20) begin
            cyc(1);
            guard++;
        end
        ok = (bus.gnt != '0);
    endtask

    // Streams words[] from requester r; optional stall, req drop or early abort.
    task automatic stream(input int r, input int stall_after, input int stall_len,
                          input int drop_after, input int abort_after, output int got);
        int  k     = 0;
        int  guard = 0;
        bit  acc;
        while (k < COL && guard < 100) begin
            bus.wdata[r*WIDTH +: WIDTH] = words[k];
            bus.wvalid[r] = 1'b1;
            acc = bus.wready[r];
            if (acc) begin
                exp_q.push_back(words[k]);
                k++;
            end
            cyc(1);
            guard++;
            if (acc && k == drop_after) bus.req[r] = 1'b0;
            if (acc && k == abort_after) break;
            if (acc && k == stall_after) begin
                bus.wvalid[r] = 1'b0;
                cyc(stall_len);
            end
        end
        bus.wvalid[r] = 1'b0;
        got = k;
    endtask

    task automatic check_outputs_reset(input string tag);
        n_total++;
        if (bus.gnt !== 2'b00 || bus.wready !== 2'b00 || bus.B_opcode !== 1'b0 ||
            bus.Data_to_B !== '0 || bus.owner !== 1'b0 || bus.done !== 1'b0 ||
            bus.matrix_valid !== 1'b0)
            $display("FAIL %s: gnt %b wready %b bop %b data %0h owner %0d done %b mv %b required all 0",
                     tag, bus.gnt, bus.wready, bus.B_opcode, bus.Data_to_B, bus.owner, bus.done,
                     bus.matrix_valid);
        else
            n_pass++;
    endtask

    task automatic check_load_done(input string tag, input int got, input int gap_req);
        n_total++;
        if (got !== COL) $display("FAIL %s_accepts: got %0d required %0d", tag, got, COL);
        else n_pass++;
        n_total++;
        if (log_ones() !== COL) $display("FAIL %s_strobes: got %0d required %0d", tag, log_ones(), COL);
        else n_pass++;
        n_total++;
        if (log_gap() !== gap_req) $display("FAIL %s_gap: got %0d required %0d", tag, log_gap(), gap_req);
        else n_pass++;
        n_total++;
        if (done_cnt !== 1) $display("FAIL %s_done_count: got %0d required 1", tag, done_cnt);
        else n_pass++;
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL %s_sb_empty: got %0d left required 0", tag, exp_q.size());
        else n_pass++;
        n_total++;
        if ({mem[3], mem[2], mem[1], mem[0]} !== {words[3], words[2], words[1], words[0]})
            $display("FAIL %s_matrix_b: got %h required %h", tag, {mem[3], mem[2], mem[1], mem[0]},
                     {words[3], words[2], words[1], words[0]});
        else n_pass++;
        n_total++;
        if (bus.matrix_valid !== 1'b1) $display("FAIL %s_matrix_valid: got %b required 1", tag,
                                                bus.matrix_valid);
        else n_pass++;
    endtask

    task automatic begin_load();
        bop_log.delete();
        done_cnt = 0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.req    = '0;
        bus.wvalid = '0;
        bus.wdata  = '0;
        cyc(2);
        check_outputs_reset("reset_held");
        reset = 1'b0;
        cyc(2);
        check_outputs_reset("reset_released");
    endtask

    task automatic test_single_load();
        int got;
        words = '{32'h11, 32'h22, 32'h33, 32'h44};
        begin_load();
        bus.req = 2'b01;
        cyc(1);
        n_total++;
        if (bus.gnt !== 2'b01 || bus.owner !== 1'b0 || bus.matrix_valid !== 1'b0)
            $display("FAIL single_gnt_latency: gnt %b owner %0d mv %b required 01 0 0",
                     bus.gnt, bus.owner, bus.matrix_valid);
        else n_pass++;
        bus.req = 2'b00;
        stream(0, -1, 0, -1, -1, got);
        n_total++;
        if (bus.done !== 1'b1 || bus.B_opcode !== 1'b1 || bus.matrix_valid !== 1'b1 ||
            bus.Data_to_B !== 32'h44)
            $display("FAIL single_done_cycle: done %b bop %b mv %b data %0h required 1 1 1 44",
                     bus.done, bus.B_opcode, bus.matrix_valid, bus.Data_to_B);
        else n_pass++;
        cyc(1);
        n_total++;
        if (bus.done !== 1'b0 || bus.B_opcode !== 1'b0)
            $display("FAIL single_done_pulse: done %b bop %b required 0 0", bus.done, bus.B_opcode);
        else n_pass++;
        cyc(1);
        check_load_done("single", got, 0);
    endtask

    task automatic test_stall();
        int got;
        bit ok;
        words = '{32'h51, 32'h52, 32'h53, 32'h54};
        begin_load();
        bus.req = 2'b10;
        wait_gnt(ok);
        n_total++;
        if (!ok || bus.owner !== 1'b1) $display("FAIL stall_owner: got %0d (gnt %b) required 1",
                                                bus.owner, bus.gnt);
        else n_pass++;
        bus.req = 2'b00;
        stream(1, 2, 3, -1, -1, got);
        cyc(2);
        check_load_done("stall", got, 3);
    endtask

    task automatic test_round_robin();
        int got;
        bit ok;
        logic exp_owner [3] = '{1'b0, 1'b1, 1'b0};
        bus.req = 2'b11;
        saw_wr1 = 1'b0;
        for (int l = 0; l < 3; l++) begin
            words = '{32'h100 + l, 32'h200 + l, 32'h300 + l, 32'h400 + l};
            begin_load();
            wait_gnt(ok);
            n_total++;
            if (!ok || bus.owner !== exp_owner[l] || bus.gnt !== (2'b01 << exp_owner[l]))
                $display("FAIL rr_owner_%0d: owner %0d gnt %b required %0d", l, bus.owner, bus.gnt,
                         exp_owner[l]);
            else n_pass++;
            if (l == 2) bus.req = 2'b00;
            stream(int'(bus.owner), -1, 0, -1, -1, got);
            cyc(1);
            check_load_done("rr", got, 0);
        end
        cyc(2);
        n_total++;
        if (bus.gnt !== 2'b00) $display("FAIL rr_no_extra_grant: gnt %b required 00", bus.gnt);
        else n_pass++;
    endtask

    task automatic test_non_granted();
        int got;
        bit ok;
        words = '{32'h61, 32'h62, 32'h63, 32'h64};
        begin_load();
        saw_dead = 1'b0;
        saw_wr1  = 1'b0;
        bus.wdata[WIDTH +: WIDTH] = 32'hDEAD;
        bus.wvalid[1] = 1'b1;
        bus.req = 2'b01;
        wait_gnt(ok);
        n_total++;
        if (!ok || bus.owner !== 1'b0) $display("FAIL nongrant_owner: got %0d required 0", bus.owner);
        else n_pass++;
        bus.req = 2'b00;
        stream(0, -1, 0, -1, -1, got);
        cyc(2);
        bus.wvalid[1] = 1'b0;
        check_load_done("nongrant", got, 0);
        n_total++;
        if (saw_dead !== 1'b0 || saw_wr1 !== 1'b0)
            $display("FAIL nongrant_ignored: dead_seen %b wready1_seen %b required 0 0",
                     saw_dead, saw_wr1);
        else n_pass++;
    endtask

    task automatic test_req_drop();
        int got;
        bit ok;
        words = '{32'h71, 32'h72, 32'h73, 32'h74};
        begin_load();
        bus.req = 2'b01;
        wait_gnt(ok);
        stream(0, -1, 0, 1, -1, got);
        cyc(2);
        check_load_done("reqdrop", got, 0);
        cyc(2);
        n_total++;
        if (bus.gnt !== 2'b00) $display("FAIL reqdrop_idle: gnt %b required 00", bus.gnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        int got;
        bit ok;
        words = '{32'h81, 32'h82, 32'h83, 32'h84};
        bus.req = 2'b01;
        wait_gnt(ok);
        bus.req = 2'b00;
        stream(0, -1, 0, -1, 2, got);
        reset = 1'b1;
        #1;
        check_outputs_reset("midload_reset_async");
        cyc(1);
        check_outputs_reset("midload_reset_next");
        reset = 1'b0;
        exp_q.delete();
        cyc(1);
        words = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        begin_load();
        // Last owner before reset was 0; reset restores priority to requester 0.
        bus.req = 2'b11;
        wait_gnt(ok);
        n_total++;
        if (!ok || bus.owner !== 1'b0) $display("FAIL midload_first_owner: got %0d required 0",
                                                bus.owner);
        else n_pass++;
        bus.req = 2'b00;
        stream(0, -1, 0, -1, -1, got);
        cyc(2);
        check_load_done("reload", got, 0);
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_stall();
        test_round_robin();
        test_non_granted();
        test_req_drop();
        test_reset_mid_load();
        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
